// File: rtl/mult_share_arbiter.sv
// Two-requester front end for one shared pipelined multiplier.
// Each requester owns a small response FIFO. A request is only granted when
// its FIFO is guaranteed to have room for the result, so results never need
// backpressure inside the multiplier pipeline.
//
// Handshake rule, same for every port pair: a transfer happens on a rising
// edge where valid and ready are both high. A source keeps valid and its data
// stable until the transfer. ready may depend combinationally on valid.
module mult_share_arbiter #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_x,
  input  logic [31:0] req0_y,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_x,
  input  logic [31:0] req1_y,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [63:0] rsp0_data,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [63:0] rsp1_data,
  output logic        mul_en,
  output logic [31:0] mul_x,
  output logic [31:0] mul_y,
  input  logic [63:0] mul_out,
  output logic        busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Tag stage 0 runs alongside the mul_x/mul_y register; the remaining
  // LATENCY stages track the multiplier's own registers, so the last stage
  // lines up with mul_out.
  logic [LATENCY:0] tag_v;
  logic [LATENCY:0] tag_id;

  logic [63:0]   mem [2][DEPTH];
  logic [PW-1:0] wp  [2];
  logic [PW-1:0] rp  [2];
  logic [CW-1:0] cnt [2];
  logic [CW-1:0] outst [2];

  // Round-robin owner: 0 favours requester 0, 1 favours requester 1.
  logic rr;

  logic [1:0] room;
  logic       elig0, elig1;
  logic       gnt0, gnt1;
  logic [1:0] issue;
  logic [1:0] push;
  logic [1:0] pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Eligibility and round-robin grant; nothing is granted while in reset.
  always_comb begin
    room  = '0;
    for (int n = 0; n < 2; n++) begin
      room[n] = (int'(outst[n]) + int'(cnt[n])) < DEPTH;
    end
    elig0 = req0_valid & room[0];
    elig1 = req1_valid & room[1];
    gnt0  = ~reset & elig0 & (~elig1 | ~rr);
    gnt1  = ~reset & elig1 & (~elig0 |  rr);
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign issue      = {gnt1, gnt0};

  // Results retire into the FIFO named by the tag leaving the last stage.
  assign push[0] = tag_v[LATENCY] & ~tag_id[LATENCY];
  assign push[1] = tag_v[LATENCY] &  tag_id[LATENCY];

  assign rsp0_valid = (cnt[0] != '0);
  assign rsp1_valid = (cnt[1] != '0);
  assign rsp0_data  = mem[0][rp[0]];
  assign rsp1_data  = mem[1][rp[1]];
  assign pop[0]     = rsp0_valid & rsp0_ready;
  assign pop[1]     = rsp1_valid & rsp1_ready;

  // The multiplier runs every cycle outside reset.
  assign mul_en = ~reset;

  assign busy = (outst[0] != '0) | (outst[1] != '0) |
                (cnt[0]   != '0) | (cnt[1]   != '0);

  // Operand registers, tag pipeline and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_x  <= '0;
      mul_y  <= '0;
      tag_v  <= '0;
      tag_id <= '0;
      rr     <= 1'b0;
    end else begin
      tag_v  <= {tag_v[LATENCY-1:0],  gnt0 | gnt1};
      tag_id <= {tag_id[LATENCY-1:0], gnt1};
      if (gnt0 | gnt1) begin
        mul_x <= gnt1 ? req1_x : req0_x;
        mul_y <= gnt1 ? req1_y : req0_y;
        rr    <= gnt0;
      end
    end
  end

  // FIFO pointers, occupancy and in-flight counters per requester.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < 2; n++) begin
        wp[n]    <= '0;
        rp[n]    <= '0;
        cnt[n]   <= '0;
        outst[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (push[n]) wp[n] <= ptr_next(wp[n]);
        if (pop[n])  rp[n] <= ptr_next(rp[n]);
        case ({push[n], pop[n]})
          2'b10:   cnt[n] <= cnt[n] + CW'(1);
          2'b01:   cnt[n] <= cnt[n] - CW'(1);
          default: cnt[n] <= cnt[n];
        endcase
        case ({issue[n], push[n]})
          2'b10:   outst[n] <= outst[n] + CW'(1);
          2'b01:   outst[n] <= outst[n] - CW'(1);
          default: outst[n] <= outst[n];
        endcase
      end
    end
  end

  // FIFO storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (push[n]) mem[n][wp[n]] <= mul_out;
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: directed corner scenarios followed by
// random traffic, checked against a transaction-level reference model.
module tb_mult_share_arbiter;

  localparam int LAT = 2;
  localparam int DEP = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [63:0] rsp0_data, rsp1_data;
  logic        mul_en;
  logic [31:0] mul_x, mul_y;
  logic [63:0] mul_out;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  // Clock / reset block
  always #5 clk = ~clk;

  mult_share_arbiter #(.LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .mul_en(mul_en), .mul_x(mul_x), .mul_y(mul_y), .mul_out(mul_out), .busy(busy)
  );

  // Shared multiplier: LAT register stages after mul_x/mul_y.
  logic [63:0] mp [LAT];
  always @(posedge clk) begin
    if (mul_en) begin
      mp[0] <= {{32{mul_x[31]}}, mul_x} * {{32{mul_y[31]}}, mul_y};
      for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
    end
  end
  assign mul_out = mp[LAT-1];

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per requester a queue of expected products and the
  // cycle each becomes visible; pend = accepted but not yet consumed.
  logic [63:0] exp_q0[$], exp_q1[$];
  int          due_q0[$], due_q1[$];
  int          pend0 = 0, pend1 = 0;
  bit          owner = 1'b0;
  int          cyc = 0;

  // Scoreboard / monitor, sampled on the falling edge.
  always @(negedge clk) begin
    bit e0, e1, g0, g1, v0, v1;
    if (reset) begin
      chk("rst_req0_ready", 64'(req0_ready), 64'd0);
      chk("rst_req1_ready", 64'(req1_ready), 64'd0);
      chk("rst_rsp0_valid", 64'(rsp0_valid), 64'd0);
      chk("rst_rsp1_valid", 64'(rsp1_valid), 64'd0);
      chk("rst_busy",       64'(busy),       64'd0);
      chk("rst_mul_en",     64'(mul_en),     64'd0);
      chk("rst_mul_x",      64'(mul_x),      64'd0);
      chk("rst_mul_y",      64'(mul_y),      64'd0);
      exp_q0.delete(); exp_q1.delete();
      due_q0.delete(); due_q1.delete();
      pend0 = 0; pend1 = 0; owner = 1'b0; cyc = 0;
    end else begin
      e0 = req0_valid && (pend0 < DEP);
      e1 = req1_valid && (pend1 < DEP);
      g0 = e0 && (!e1 || owner == 1'b0);
      g1 = e1 && (!e0 || owner == 1'b1);
      chk("req0_ready", 64'(req0_ready), 64'(g0));
      chk("req1_ready", 64'(req1_ready), 64'(g1));
      chk("mul_en", 64'(mul_en), 64'd1);
      chk("busy", 64'(busy), 64'((pend0 + pend1) != 0));

      v0 = (due_q0.size() > 0) && (due_q0[0] <= cyc);
      chk("rsp0_valid", 64'(rsp0_valid), 64'(v0));
      if (v0) begin
        chk("rsp0_data", rsp0_data, exp_q0[0]);
        if (rsp0_ready) begin
          void'(exp_q0.pop_front()); void'(due_q0.pop_front()); pend0--;
        end
      end
      v1 = (due_q1.size() > 0) && (due_q1[0] <= cyc);
      chk("rsp1_valid", 64'(rsp1_valid), 64'(v1));
      if (v1) begin
        chk("rsp1_data", rsp1_data, exp_q1[0]);
        if (rsp1_ready) begin
          void'(exp_q1.pop_front()); void'(due_q1.pop_front()); pend1--;
        end
      end

      if (g0) begin
        exp_q0.push_back(ref_mul(req0_x, req0_y));
        due_q0.push_back(cyc + LAT + 2);
        pend0++; owner = 1'b1;
      end else if (g1) begin
        exp_q1.push_back(ref_mul(req1_x, req1_y));
        due_q1.push_back(cyc + LAT + 2);
        pend1++; owner = 1'b0;
      end
      cyc++;
    end
  end

  // Driver tasks
  logic acc0, acc1;

  task automatic step();
    @(negedge clk);
    acc0 = req0_valid & req0_ready;
    acc1 = req1_valid & req1_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_both();
    for (int i = 0; i < 40 && (req0_valid || req1_valid); i++) begin
      step();
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
    end
    if (req0_valid || req1_valid) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: got valid pending expected accepted");
      req0_valid = 1'b0; req1_valid = 1'b0;
    end
  endtask

  task automatic stream0(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (acc0) begin req0_x = $urandom; req0_y = $urandom; end
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h0;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] cx [3];
  logic [31:0] cy [3];

  initial begin
    cx[0] = 32'h8000_0000; cy[0] = 32'h8000_0000;
    cx[1] = 32'h8000_0000; cy[1] = 32'h7FFF_FFFF;
    cx[2] = 32'h7FFF_FFFF; cy[2] = 32'h7FFF_FFFF;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Single request latency and data
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_x = 32'h7FFF_FFFF; req0_y = 32'h1;
    wait_both();
    repeat (6) step();

    // Both requesters right after reset: requester 0 first
    reset = 1'b1; step(); reset = 1'b0;
    req0_valid = 1'b1; req0_x = 32'hFFFF_FFFE; req0_y = 32'hFFFF_FFFE;
    req1_valid = 1'b1; req1_x = 32'h2;         req1_y = 32'hFFFF_FFFE;
    wait_both();
    repeat (6) step();

    // Requester 0 blocked by its full FIFO; requester 1 still served
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_x = $urandom; req0_y = $urandom;
    stream0(10);
    req1_valid = 1'b1; req1_x = 32'h3; req1_y = 32'hFFFF_FFFF;
    for (int i = 0; i < 20 && req1_valid; i++) begin
      step();
      if (acc0) begin req0_x = $urandom; req0_y = $urandom; end
      if (acc1) req1_valid = 1'b0;
    end

    // Drain while requester 0 keeps pushing
    rsp0_ready = 1'b1;
    stream0(20);
    req0_valid = 1'b0;
    repeat (8) step();

    // Extreme operand corners through requester 1
    for (int k = 0; k < 3; k++) begin
      req1_valid = 1'b1; req1_x = cx[k]; req1_y = cy[k];
      wait_both();
    end
    repeat (6) step();

    // Reset shortly after two accepts discards everything
    req0_valid = 1'b1; req0_x = 32'h1234; req0_y = 32'h5678;
    req1_valid = 1'b1; req1_x = 32'h9;    req1_y = 32'h7;
    wait_both();
    step();
    reset = 1'b1; req0_valid = 1'b1;
    step(); step();
    req0_valid = 1'b0; reset = 1'b0;
    repeat (8) step();

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      if (!req0_valid || acc0) begin
        req0_valid = ($urandom_range(0, 99) < 60);
        req0_x = pick(); req0_y = pick();
      end
      if (!req1_valid || acc1) begin
        req1_valid = ($urandom_range(0, 99) < 60);
        req1_x = pick(); req1_y = pick();
      end
      rsp0_ready = ($urandom_range(0, 99) < 70);
      rsp1_ready = ($urandom_range(0, 99) < 70);
      step();
    end

    // Drain
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
